// File: rtl/alu_share_pkg.sv
// Shared types, opcodes and the op evaluator for the shared ALU sequencer.
// Operands arrive sign-extended to MAXW so one compare path serves SLT and SLTU.
package alu_share_pkg;

  localparam int MAXW = 64;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Sign extension keeps unsigned order, so a<b on the wide values is SLTU.
  function automatic logic [MAXW-1:0] alu_eval(
    input logic [2:0]      op,
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b
  );
    logic [MAXW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {{(MAXW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(MAXW-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Grant is one-hot, or zero when nobody requests.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU among NREQ requesters: grant, execute one cycle,
// then hold the result for the owner until it is taken.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_res,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  ready_c;
  logic [MAXW-1:0]  a_ext, b_ext;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    a_ext = MAXW'(signed'(a_q));
    b_ext = MAXW'(signed'(b_q));
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    ready_c   = '0;
    rsp_valid = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready_c = grant;
        for (int i = 0; i < NREQ; i++) begin
          if (grant[i]) begin
            owner_d = IW'(i);
            op_d    = req_op[3*i +: 3];
            a_d     = req_a[WIDTH*i +: WIDTH];
            b_d     = req_b[WIDTH*i +: WIDTH];
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d   = WIDTH'(alu_eval(op_q, a_ext, b_ext));
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
          if (int'(owner_q) == NREQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = owner_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is combinational off the arbiter, so hold it low during reset.
  assign req_ready = rst_n ? ready_c : '0;
  assign rsp_res   = res_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: opcode table, arbitration order,
// backpressure and asynchronous reset in EXEC and RESP.
module tb_alu_share_ctrl;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*3-1:0]     req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_res;
  logic                  busy;

  alu_share_ctrl #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[10];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status();
    return {27'b0, busy, req_ready, rsp_valid};
  endfunction

  function automatic logic [1:0] onehot(input int who);
    logic [1:0] v;
    v = 2'b01 << who;
    return v;
  endfunction

  task automatic drive(input int who, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid[who]      = 1'b1;
    req_op[3*who +: 3]  = op;
    req_a[32*who +: 32] = a;
    req_b[32*who +: 32] = b;
  endtask

  // Entered just after a negedge with the request driven; leaves in EXEC.
  task automatic start_op(input int who, input string name);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "/grant"}, {30'b0, req_ready}, {30'b0, onehot(who)});
    @(negedge clk);
    req_valid[who] = 1'b0;
    #1;
    chk({name, "/exec"}, status(), {27'b0, 1'b1, 2'b00, 2'b00});
  endtask

  task automatic finish_op(input int who, input logic [31:0] exp,
                           input int hold, input string name);
    @(negedge clk);
    #1;
    chk({name, "/rsp"}, status(), {27'b0, 1'b1, 2'b00, onehot(who)});
    chk({name, "/res"}, rsp_res, exp);
    for (int c = 0; c < hold; c++) begin
      rsp_ready = ~onehot(who);
      @(negedge clk);
      #1;
      chk({name, "/hold"}, status(), {27'b0, 1'b1, 2'b00, onehot(who)});
      chk({name, "/hold_res"}, rsp_res, exp);
    end
    rsp_ready = onehot(who);
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk({name, "/idle"}, {29'b0, busy, rsp_valid}, 32'h0);
  endtask

  task automatic serve(input int who, input logic [31:0] exp,
                       input int hold, input string name);
    start_op(who, name);
    finish_op(who, exp, hold, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_1_m1"};
    tbl[1] = '{0, 3'd6, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_1_m1"};
    tbl[2] = '{1, 3'd0, 32'hF0F0_0000, 32'h0FF0_0001, 32'h00E0_0001, "add"};
    tbl[3] = '{0, 3'd1, 32'hF0F0_0000, 32'h0FF0_0001, 32'hE0FF_FFFF, "sub"};
    tbl[4] = '{1, 3'd2, 32'hF0F0_0000, 32'h0FF0_0001, 32'h00F0_0000, "and"};
    tbl[5] = '{0, 3'd3, 32'hF0F0_0000, 32'h0FF0_0001, 32'hFFF0_0001, "or"};
    tbl[6] = '{1, 3'd4, 32'hF0F0_0000, 32'h0FF0_0001, 32'hFF00_0001, "xor"};
    tbl[7] = '{0, 3'd5, 32'hF0F0_0000, 32'h0FF0_0001, 32'h000F_FFFE, "nor"};
    tbl[8] = '{1, 3'd6, 32'hF0F0_0000, 32'h0FF0_0001, 32'h0000_0001, "slt"};
    tbl[9] = '{1, 3'd7, 32'hF0F0_0000, 32'h0FF0_0001, 32'h0000_0000, "sltu"};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // Both requesters valid through reset: ready must stay gated.
    drive(0, 3'd0, 32'd3, 32'd4);
    drive(1, 3'd1, 32'd3, 32'd4);
    #12;
    chk("reset/status", status(), 32'h0);
    chk("reset/res", rsp_res, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: grant order 0,1 then again 0,1.
    serve(0, 32'd7, 0, "cont0_a");
    serve(1, 32'hFFFF_FFFF, 0, "cont1_a");
    drive(0, 3'd0, 32'd3, 32'd4);
    drive(1, 3'd1, 32'd3, 32'd4);
    serve(0, 32'd7, 0, "cont0_b");
    serve(1, 32'hFFFF_FFFF, 0, "cont1_b");

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].who, tbl[k].op, tbl[k].a, tbl[k].b);
      serve(tbl[k].who, tbl[k].exp, 0, tbl[k].name);
    end

    // Backpressure with a competing request pending.
    drive(0, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F);
    drive(1, 3'd3, 32'h1200_0000, 32'h0000_0034);
    serve(0, 32'h0204_0608, 5, "bp0");
    serve(1, 32'h1200_0034, 0, "bp1");

    // Leave ptr at 1, then reset while req1 is in RESP.
    drive(0, 3'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    serve(0, 32'h5555_5555, 0, "pre_rst");
    drive(1, 3'd0, 32'd10, 32'd20);
    start_op(1, "rst_resp");
    @(negedge clk);
    #1;
    chk("rst_resp/valid", {30'b0, rsp_valid}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rst_resp/clear", status(), 32'h0);
    drive(0, 3'd0, 32'd1, 32'd2);
    drive(1, 3'd1, 32'd9, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 32'd3, 0, "post_rst0");
    serve(1, 32'd7, 0, "post_rst1");

    // Reset during EXEC: no response may appear afterwards.
    drive(0, 3'd0, 32'd5, 32'd6);
    start_op(0, "rst_exec");
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_exec/clear", status(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_exec/quiet", status(), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
